alu_issue_ctrl: RTL

- Issue/writeback stage wrapped around the 16-bit ALU.
- Accepts one ALU instruction at a time over a valid/ready handshake and reads two operands from an internal register file.
- Drives the ALU operand/select/mode/carry inputs from registers, then captures the ALU result, carry-out and compare back into the register file and status flags.
- The ALU itself sits outside this block; it is connected through the alu_* ports.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_regfile.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU issue/writeback slice.
//   ALU_DATA_W     default operand/result width of the external 16-bit ALU
//   LOG_* / ARI_*  ALU function-select codes (4 bits)
//   MODE_LOGIC / MODE_ARITH  values of the ALU mode input
//   issue_state_t  issue controller states
package alu_pkg;

   localparam int ALU_DATA_W = 16;

   // Logic-mode selects
   localparam logic [3:0] LOG_NOT_A  = 4'b0000;
   localparam logic [3:0] LOG_ZERO   = 4'b0011;
   localparam logic [3:0] LOG_XOR    = 4'b0110;
   localparam logic [3:0] LOG_AND    = 4'b1011;
   localparam logic [3:0] LOG_OR     = 4'b1110;
   localparam logic [3:0] LOG_PASS_A = 4'b1111;

   // Arithmetic-mode selects
   localparam logic [3:0] ARI_ORPLUS = 4'b0101;
   localparam logic [3:0] ARI_SUB    = 4'b0110;
   localparam logic [3:0] ARI_ADD    = 4'b1001;
   localparam logic [3:0] ARI_DOUBLE = 4'b1100;

   localparam logic MODE_LOGIC = 1'b0;
   localparam logic MODE_ARITH = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } issue_state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NUM_REGS x DATA_W register file.
//   clk, rst_n                       clock, async active-low reset (clears all entries)
//   rd_addr_a/rd_data_a              combinational read port A
//   rd_addr_b/rd_data_b              combinational read port B
//   dbg_addr/dbg_data                combinational debug read port
//   wb_en/wb_addr/wb_data            writeback port (highest priority)
//   host_en/host_addr/host_data      host load port
module alu_regfile #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 16,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [AW-1:0]     rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [AW-1:0]     dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              host_en,
   input  logic [AW-1:0]     host_addr,
   input  logic [DATA_W-1:0] host_data
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   // Reads return the contents before the current edge; no write-through.
   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];
   assign dbg_data  = mem[dbg_addr];

   // When both ports hit the same entry, the writeback wins and the host write is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wb_en && (wb_addr == AW'(i))) begin
               mem[i] <= wb_data;
            end else if (host_en && (host_addr == AW'(i))) begin
               mem[i] <= host_data;
            end
         end
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback stage wrapped around an external 16-bit ALU.
//   Accepts one instruction per 3 cycles (IDLE -> EXEC -> WB), reads operands from an
//   internal register file, drives the ALU from registers, and writes the ALU result,
//   carry and compare back into the register file and status flags.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   instr_valid/instr_ready            instruction handshake (ready only in IDLE)
//   instr_select/mode/use_carry        ALU function controls
//   instr_ra/rb/rd                     source and destination registers
//   host_wr_en/addr/data               direct register load (any state, loses to writeback)
//   host_rd_addr/host_rd_data          combinational debug read
//   alu_in_a/b, alu_select, alu_mode, alu_carry_in   registered ALU inputs
//   alu_result, alu_carry_out, alu_compare           ALU outputs
//   result_valid/result_data           writeback pulse and held written value
//   carry_flag, compare_flag           architectural flags
//   zero_flag, neg_flag                status flags, only generated when the
//                                      ALU_STATUS_FLAGS_EN macro is defined (else tied 0)
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W   = ALU_DATA_W,
   parameter int NUM_REGS = 8,
   parameter int REG_AW   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_select,
   input  logic              instr_mode,
   input  logic              instr_use_carry,
   input  logic [REG_AW-1:0] instr_ra,
   input  logic [REG_AW-1:0] instr_rb,
   input  logic [REG_AW-1:0] instr_rd,
   input  logic              host_wr_en,
   input  logic [REG_AW-1:0] host_wr_addr,
   input  logic [DATA_W-1:0] host_wr_data,
   input  logic [REG_AW-1:0] host_rd_addr,
   output logic [DATA_W-1:0] host_rd_data,
   output logic [DATA_W-1:0] alu_in_a,
   output logic [DATA_W-1:0] alu_in_b,
   output logic [3:0]        alu_select,
   output logic              alu_mode,
   output logic              alu_carry_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry_out,
   input  logic              alu_compare,
   output logic              result_valid,
   output logic [DATA_W-1:0] result_data,
   output logic              carry_flag,
   output logic              compare_flag,
   output logic              zero_flag,
   output logic              neg_flag
);

   issue_state_t      state_q, state_d;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] stage_result;
   logic              stage_carry;
   logic              stage_cmp;
   logic [DATA_W-1:0] rf_a, rf_b;
   logic              accept;
   logic              wb_en;

   assign accept = instr_valid && instr_ready;
   assign wb_en  = (state_q == WB);

   alu_regfile #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .AW       (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (instr_ra),
      .rd_data_a (rf_a),
      .rd_addr_b (instr_rb),
      .rd_data_b (rf_b),
      .dbg_addr  (host_rd_addr),
      .dbg_data  (host_rd_data),
      .wb_en     (wb_en),
      .wb_addr   (rd_q),
      .wb_data   (stage_result),
      .host_en   (host_wr_en),
      .host_addr (host_wr_addr),
      .host_data (host_wr_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      instr_ready  = 1'b0;
      result_valid = 1'b0;
      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_d = EXEC;
            end
         end
         EXEC: state_d = WB;
         WB: begin
            result_valid = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The instruction is sampled only on the accept edge; alu_mode doubles as the
   // latched mode that decides whether the carry flag is updated at writeback.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_in_a     <= '0;
         alu_in_b     <= '0;
         alu_select   <= '0;
         alu_mode     <= 1'b0;
         alu_carry_in <= 1'b0;
         rd_q         <= '0;
      end else if (accept) begin
         alu_in_a     <= rf_a;
         alu_in_b     <= rf_b;
         alu_select   <= instr_select;
         alu_mode     <= instr_mode;
         alu_carry_in <= instr_use_carry & carry_flag;
         rd_q         <= instr_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_result <= '0;
         stage_carry  <= 1'b0;
         stage_cmp    <= 1'b0;
      end else if (state_q == EXEC) begin
         stage_result <= alu_result;
         stage_carry  <= alu_carry_out;
         stage_cmp    <= alu_compare;
      end
   end

   // Logic operations leave the architectural carry untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_data  <= '0;
         compare_flag <= 1'b0;
         carry_flag   <= 1'b0;
      end else if (wb_en) begin
         result_data  <= stage_result;
         compare_flag <= stage_cmp;
         if (alu_mode == MODE_ARITH) begin
            carry_flag <= stage_carry;
         end
      end
   end

`ifdef ALU_STATUS_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_flag <= 1'b0;
         neg_flag  <= 1'b0;
      end else if (wb_en) begin
         zero_flag <= (stage_result == '0);
         neg_flag  <= stage_result[DATA_W-1];
      end
   end
`else
   assign zero_flag = 1'b0;
   assign neg_flag  = 1'b0;
`endif

endmodule
